puf_eval_scheduler: RTL

//  Sequences PUF evaluations between the SPI command decoder and the DD/XOR PUF cores.

---
 rtl/puf_ctrl_pkg.sv | 26 ++
 rtl/puf_watchdog.sv | 28 ++
 rtl/puf_eval_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/puf_ctrl_pkg.sv
// rtl/puf_ctrl_pkg.sv - command codes, response ids, state encoding and widths for the PUF scheduler
package puf_ctrl_pkg;

    localparam int DATA_W_DFLT = 128;
    localparam int CODE_W_DFLT = 8;

    // Command codes arriving from the SPI decoder
    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_DD   = 8'h01;
    localparam logic [7:0] CMD_XOR  = 8'h02;
    localparam logic [7:0] CMD_BOTH = 8'h03;

    // Response codes returned to the SPI sender
    localparam logic [7:0] RESP_ID_DD   = 8'h01;
    localparam logic [7:0] RESP_ID_XOR  = 8'h02;
    localparam logic [7:0] RESP_INVALID = 8'hFF;
    localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

endpackage

// File: rtl/puf_watchdog.sv
// rtl/puf_watchdog.sv - WAIT-state cycle watchdog, instantiated only when PUF_TIMEOUT_EN is defined
module puf_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Cleared by load, advanced once per enabled cycle; holds once expired
    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires during the LIMIT-th enabled cycle since the last load
    assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/puf_eval_scheduler.sv
// rtl/puf_eval_scheduler.sv - sequences DD/XOR PUF evaluations; optional WAIT timeout under PUF_TIMEOUT_EN
module puf_eval_scheduler
    import puf_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CODE_W = CODE_W_DFLT,
    parameter int CNT_W  = 16
`ifdef PUF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [CODE_W-1:0]        CMD_CODE,
    input  logic [DATA_W-1:0]        CMD_CHAL,
    output logic [DATA_W-1:0]        CHAL_OUT,
    output logic                     START_DD,
    output logic                     START_XOR,
    input  logic                     DONE_DD,
    input  logic                     DONE_XOR,
    input  logic [DATA_W-1:0]        PUF_OUT_DD,
    input  logic [DATA_W-1:0]        PUF_OUT_XOR,
    output logic                     RESP_VALID,
    input  logic                     RESP_READY,
    output logic [CODE_W+DATA_W-1:0] RESP_DATA,
    output logic [CNT_W-1:0]         CNT_VAL,
    output logic                     BUSY
);

    state_t                     state_q;
    logic [CODE_W-1:0]          code_q;
    logic                       sel_xor_q;   // pass in flight targets the XOR core
    logic [DATA_W-1:0]          chal_q;
    logic                       start_dd_q;
    logic                       start_xor_q;
    logic                       cmd_ready_q;
    logic                       busy_q;
    logic                       resp_valid_q;
    logic [CODE_W+DATA_W-1:0]   resp_data_q;
    logic [CNT_W-1:0]           cnt_q;

    logic                       done_sel;
    logic [DATA_W-1:0]          puf_sel;
    logic [CODE_W-1:0]          id_sel;

    // Route only the selected core's DONE/response into the WAIT logic
    always_comb begin
        done_sel = DONE_DD;
        puf_sel  = PUF_OUT_DD;
        id_sel   = CODE_W'(RESP_ID_DD);
        if (sel_xor_q) begin
            done_sel = DONE_XOR;
            puf_sel  = PUF_OUT_XOR;
            id_sel   = CODE_W'(RESP_ID_XOR);
        end
    end

`ifdef PUF_TIMEOUT_EN
    logic wd_expire;

    puf_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .load_i   (state_q == ST_LAUNCH),
        .en_i     (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );
`endif

    // Scheduler FSM with registered handshake, start and response outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            code_q       <= CODE_W'(CMD_NOP);
            sel_xor_q    <= 1'b0;
            chal_q       <= '0;
            start_dd_q   <= 1'b0;
            start_xor_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            start_dd_q  <= 1'b0;
            start_xor_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (CMD_VALID && cmd_ready_q) begin
                        code_q      <= CMD_CODE;
                        chal_q      <= CMD_CHAL;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (CMD_CODE == CODE_W'(CMD_DD) || CMD_CODE == CODE_W'(CMD_BOTH)) begin
                            sel_xor_q  <= 1'b0;
                            start_dd_q <= 1'b1;
                            state_q    <= ST_LAUNCH;
                        end else if (CMD_CODE == CODE_W'(CMD_XOR)) begin
                            sel_xor_q   <= 1'b1;
                            start_xor_q <= 1'b1;
                            state_q     <= ST_LAUNCH;
                        end else begin
                            sel_xor_q    <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= {CODE_W'(RESP_INVALID), {DATA_W{1'b0}}};
                            state_q      <= ST_SEND;
                        end
                    end
                end
                ST_LAUNCH: begin
                    // DONE during the start cycle is deliberately not sampled
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_sel) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= {id_sel, puf_sel};
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        state_q <= ST_SEND;
                    end
`ifdef PUF_TIMEOUT_EN
                    else if (wd_expire) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= {CODE_W'(RESP_TIMEOUT), {DATA_W{1'b0}}};
                        // Forget the BOTH request so a timed-out DD pass ends the chain
                        code_q       <= CODE_W'(CMD_NOP);
                        state_q      <= ST_SEND;
                    end
`endif
                end
                ST_SEND: begin
                    if (RESP_READY) begin
                        resp_valid_q <= 1'b0;
                        if (code_q == CODE_W'(CMD_BOTH) && !sel_xor_q) begin
                            sel_xor_q   <= 1'b1;
                            start_xor_q <= 1'b1;
                            state_q     <= ST_LAUNCH;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            chal_q      <= '0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY  = cmd_ready_q;
    assign CHAL_OUT   = chal_q;
    assign START_DD   = start_dd_q;
    assign START_XOR  = start_xor_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_DATA  = resp_data_q;
    assign CNT_VAL    = cnt_q;
    assign BUSY       = busy_q;

endmodule
